// File: rtl/virtual_stream_source_if.sv
// Valid/ready flit stream between a traffic source and a cast input port.
// No logic of its own; modports fix the direction of each signal.
// Backpressure: ready from the sink, valid and data from the source.
`ifndef DW
`define DW 32
`endif

interface virtual_stream_source_if;
    logic             valid;
    logic [`DW-1:0]   data;
    logic             ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/virtual_stream_source.sv
// Deadlock-probe traffic generator: PKT_NUM packets of PKT_LEN flits tagged with stream_id.
// Latency: first flit valid 1 cycle after start_i is sampled; done_o 1 cycle after the last tail.
// Backpressure: flit held stable until accepted; a stall of TIMEOUT cycles sets a sticky deadlock flag.
`ifndef DW
`define DW 32
`endif

module virtual_stream_source #(
    parameter logic [9:0] stream_id = 10'd0,
    parameter int         PKT_NUM   = 16,
    parameter int         PKT_LEN   = 8,
    parameter int         GAP       = 0,
    parameter int         TIMEOUT   = 1024
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start_i,
    virtual_stream_source_if.master        tx,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           deadlock_o,
    output logic [15:0]                    sent_cnt_o
);
    localparam int DW = `DW;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_HEAD = 3'd1;
    localparam logic [2:0] S_BODY = 3'd2;
    localparam logic [2:0] S_TAIL = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [15:0] LAST_BODY = 16'(PKT_LEN - 2);
    localparam logic [15:0] LAST_PKT  = 16'(PKT_NUM - 1);
    localparam logic [7:0]  LAST_GAP  = 8'(GAP - 1);
    localparam logic [31:0] STALL_LIM = 32'(TIMEOUT - 1);

    logic [2:0]    state;
    logic [15:0]   pkt_idx;
    logic [15:0]   flit_idx;
    logic [7:0]    gap_cnt;
    logic [15:0]   sent_cnt;
    logic [31:0]   stall_cnt;
    logic          done_q;
    logic          deadlock_q;
    logic          valid;
    logic          xfer;
    logic [DW-1:0] flit_dat;

    // valid comes from registered state only, never from ready
    assign valid = (state == S_HEAD) || (state == S_BODY) || (state == S_TAIL);
    assign xfer  = valid && tx.ready;

    always_comb begin
        flit_dat = '0;
        case (state)
            S_HEAD: begin
                flit_dat[DW-1:DW-2] = 2'b01;
                flit_dat[25:10]     = pkt_idx;
                flit_dat[9:0]       = stream_id;
            end
            S_BODY: begin
                flit_dat[DW-1:DW-2] = 2'b00;
                flit_dat[25:16]     = stream_id;
                flit_dat[15:0]      = flit_idx;
            end
            S_TAIL: begin
                flit_dat[DW-1:DW-2] = 2'b10;
                flit_dat[25:16]     = stream_id;
                flit_dat[15:0]      = flit_idx;
            end
            default: flit_dat = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            pkt_idx    <= '0;
            flit_idx   <= '0;
            gap_cnt    <= '0;
            sent_cnt   <= '0;
            stall_cnt  <= '0;
            done_q     <= 1'b0;
            deadlock_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state    <= S_HEAD;
                        pkt_idx  <= '0;
                        flit_idx <= '0;
                        sent_cnt <= '0;
                        done_q   <= 1'b0;
                    end
                end
                S_HEAD: begin
                    if (xfer) begin
                        flit_idx <= 16'd1;
                        state    <= (PKT_LEN > 2) ? S_BODY : S_TAIL;
                    end
                end
                S_BODY: begin
                    if (xfer) begin
                        flit_idx <= flit_idx + 16'd1;
                        if (flit_idx == LAST_BODY) state <= S_TAIL;
                    end
                end
                S_TAIL: begin
                    if (xfer) begin
                        sent_cnt <= sent_cnt + 16'd1;
                        pkt_idx  <= pkt_idx + 16'd1;
                        flit_idx <= '0;
                        gap_cnt  <= '0;
                        if (pkt_idx == LAST_PKT) begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                        end else if (GAP > 0) begin
                            state <= S_GAP;
                        end else begin
                            state <= S_HEAD;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == LAST_GAP) state <= S_HEAD;
                    else                     gap_cnt <= gap_cnt + 8'd1;
                end
                default: state <= S_IDLE;
            endcase

            // stall watchdog: saturating, cleared by any transfer or idle cycle
            if (valid && !tx.ready) begin
                if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
                if (stall_cnt >= STALL_LIM) deadlock_q <= 1'b1;
            end else begin
                stall_cnt <= '0;
            end
        end
    end

    assign tx.valid   = valid;
    assign tx.data    = flit_dat;
    assign busy_o     = valid || (state == S_GAP);
    assign done_o     = done_q;
    assign deadlock_o = deadlock_q;
    assign sent_cnt_o = sent_cnt;
endmodule

// File: tb/tb_virtual_stream_source.sv
// Directed bench for virtual_stream_source: framing, gaps, backpressure, watchdog, reset and restart.
`ifndef DW
`define DW 32
`endif

module tb_virtual_stream_source;
    logic clk = 1'b0;
    logic rstn;
    logic start_a, start_b;
    logic busy_a, done_a, dl_a, busy_b, done_b, dl_b;
    logic [15:0] sent_a, sent_b;
    int tests = 0;
    int fails = 0;

    logic [31:0] exp_a [8];
    logic [31:0] exp_b [12];
    logic        vld_b [12];

    virtual_stream_source_if if_a();
    virtual_stream_source_if if_b();

    always #5 clk = ~clk;

    virtual_stream_source #(.stream_id(10'h2A), .PKT_NUM(2), .PKT_LEN(4), .GAP(0), .TIMEOUT(16)) dut_a (
        .clk(clk), .rstn(rstn), .start_i(start_a), .tx(if_a),
        .busy_o(busy_a), .done_o(done_a), .deadlock_o(dl_a), .sent_cnt_o(sent_a));

    virtual_stream_source #(.stream_id(10'h155), .PKT_NUM(3), .PKT_LEN(2), .GAP(3), .TIMEOUT(1024)) dut_b (
        .clk(clk), .rstn(rstn), .start_i(start_b), .tx(if_b),
        .busy_o(busy_b), .done_o(done_b), .deadlock_o(dl_b), .sent_cnt_o(sent_b));

    task automatic test_reset();
        rstn = 1'b0; start_a = 1'b0; start_b = 1'b0;
        if_a.ready = 1'b0; if_b.ready = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (if_a.valid !== 1'b0) begin fails++; $display("FAIL reset_valid_a got %b want 0", if_a.valid); end
        tests++; if (if_a.data !== 32'h0) begin fails++; $display("FAIL reset_data_a got %h want 0", if_a.data); end
        tests++; if ({busy_a, done_a, dl_a} !== 3'b000) begin fails++; $display("FAIL reset_flags_a got %b want 000", {busy_a, done_a, dl_a}); end
        tests++; if (sent_a !== 16'd0) begin fails++; $display("FAIL reset_sent_a got %0d want 0", sent_a); end
        tests++; if ({if_b.valid, busy_b, done_b, dl_b} !== 4'b0000) begin fails++; $display("FAIL reset_flags_b got %b want 0000", {if_b.valid, busy_b, done_b, dl_b}); end
        rstn = 1'b1;
        @(negedge clk);
        tests++; if (if_a.valid !== 1'b0) begin fails++; $display("FAIL idle_no_start got valid %b want 0", if_a.valid); end
    endtask

    task automatic test_basic();
        if_a.ready = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            tests++; if (if_a.valid !== 1'b1 || if_a.data !== exp_a[i]) begin
                fails++; $display("FAIL basic_flit%0d got v=%b d=%h want v=1 d=%h", i, if_a.valid, if_a.data, exp_a[i]);
            end
            tests++; if (busy_a !== 1'b1 || done_a !== 1'b0) begin
                fails++; $display("FAIL basic_busy%0d got busy=%b done=%b want 1/0", i, busy_a, done_a);
            end
        end
        @(negedge clk);
        tests++; if (done_a !== 1'b1 || sent_a !== 16'd2 || busy_a !== 1'b0 || if_a.valid !== 1'b0) begin
            fails++; $display("FAIL basic_done got done=%b sent=%0d busy=%b v=%b want 1/2/0/0", done_a, sent_a, busy_a, if_a.valid);
        end
    endtask

    task automatic test_gap();
        if_b.ready = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            tests++; if (if_b.valid !== vld_b[i]) begin
                fails++; $display("FAIL gap_valid%0d got %b want %b", i, if_b.valid, vld_b[i]);
            end
            if (vld_b[i]) begin
                tests++; if (if_b.data !== exp_b[i]) begin
                    fails++; $display("FAIL gap_data%0d got %h want %h", i, if_b.data, exp_b[i]);
                end
            end
            tests++; if (done_b !== 1'b0) begin fails++; $display("FAIL gap_early_done%0d got %b want 0", i, done_b); end
        end
        @(negedge clk);
        tests++; if (done_b !== 1'b1 || sent_b !== 16'd3 || if_b.valid !== 1'b0) begin
            fails++; $display("FAIL gap_done got done=%b sent=%0d v=%b want 1/3/0", done_b, sent_b, if_b.valid);
        end
    endtask

    task automatic test_busy_ignore();
        if_a.ready = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            start_a = (i >= 1 && i <= 5);
            tests++; if (if_a.valid !== 1'b1 || if_a.data !== exp_a[i]) begin
                fails++; $display("FAIL busy_flit%0d got v=%b d=%h want v=1 d=%h", i, if_a.valid, if_a.data, exp_a[i]);
            end
        end
        start_a = 1'b0;
        @(negedge clk);
        tests++; if (done_a !== 1'b1 || sent_a !== 16'd2) begin
            fails++; $display("FAIL busy_done got done=%b sent=%0d want 1/2", done_a, sent_a);
        end
    endtask

    task automatic test_done_restart();
        if_a.ready = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        tests++; if (done_a !== 1'b0 || sent_a !== 16'd0) begin
            fails++; $display("FAIL restart_clear got done=%b sent=%0d want 0/0", done_a, sent_a);
        end
        tests++; if (if_a.valid !== 1'b1 || if_a.data !== exp_a[0] || busy_a !== 1'b1) begin
            fails++; $display("FAIL restart_head got v=%b d=%h busy=%b want 1/%h/1", if_a.valid, if_a.data, busy_a, exp_a[0]);
        end
    endtask

    task automatic test_deadlock();
        @(negedge clk);
        if_a.ready = 1'b0;
        tests++; if (if_a.data !== exp_a[1]) begin fails++; $display("FAIL dl_body1 got %h want %h", if_a.data, exp_a[1]); end
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            tests++; if (dl_a !== (k == 16)) begin
                fails++; $display("FAIL dl_flag_stall%0d got %b want %b", k, dl_a, (k == 16));
            end
            tests++; if (if_a.valid !== 1'b1 || if_a.data !== exp_a[1]) begin
                fails++; $display("FAIL dl_hold%0d got v=%b d=%h want 1/%h", k, if_a.valid, if_a.data, exp_a[1]);
            end
        end
        if_a.ready = 1'b1;
        for (int i = 2; i < 8; i++) begin
            @(negedge clk);
            tests++; if (if_a.valid !== 1'b1 || if_a.data !== exp_a[i]) begin
                fails++; $display("FAIL dl_resume%0d got v=%b d=%h want 1/%h", i, if_a.valid, if_a.data, exp_a[i]);
            end
        end
        @(negedge clk);
        tests++; if (done_a !== 1'b1 || dl_a !== 1'b1 || sent_a !== 16'd2) begin
            fails++; $display("FAIL dl_done got done=%b dl=%b sent=%0d want 1/1/2", done_a, dl_a, sent_a);
        end
    endtask

    task automatic test_reset_mid();
        if_a.ready = 1'b1;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (if_a.data !== exp_a[2]) begin fails++; $display("FAIL mid_pre got %h want %h", if_a.data, exp_a[2]); end
        rstn = 1'b0;
        #1;
        tests++; if ({if_a.valid, busy_a, done_a, dl_a} !== 4'b0000 || sent_a !== 16'd0 || if_a.data !== 32'h0) begin
            fails++; $display("FAIL mid_async got v/b/d/dl=%b sent=%0d d=%h want 0000/0/0", {if_a.valid, busy_a, done_a, dl_a}, sent_a, if_a.data);
        end
        #1 rstn = 1'b1;
        @(negedge clk);
        tests++; if (if_a.valid !== 1'b0) begin fails++; $display("FAIL mid_idle got v=%b want 0", if_a.valid); end
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            tests++; if (if_a.valid !== 1'b1 || if_a.data !== exp_a[i]) begin
                fails++; $display("FAIL mid_fresh%0d got v=%b d=%h want 1/%h", i, if_a.valid, if_a.data, exp_a[i]);
            end
        end
        @(negedge clk);
        tests++; if (done_a !== 1'b1 || sent_a !== 16'd2) begin
            fails++; $display("FAIL mid_done got done=%b sent=%0d want 1/2", done_a, sent_a);
        end
    endtask

    task automatic test_random_ready();
        int          got = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_dat = '0;
        logic        rdy;
        if_a.ready = 1'b0;
        start_a = 1'b1;
        for (int cyc = 0; cyc < 400 && got < 8; cyc++) begin
            @(negedge clk);
            start_a = 1'b0;
            if (prev_stall) begin
                tests++; if (if_a.valid !== 1'b1 || if_a.data !== prev_dat) begin
                    fails++; $display("FAIL rnd_stable cyc%0d got v=%b d=%h want 1/%h", cyc, if_a.valid, if_a.data, prev_dat);
                end
            end
            rdy = ($urandom_range(0, 99) < 30);
            if_a.ready = rdy;
            if (if_a.valid === 1'b1 && rdy) begin
                tests++; if (if_a.data !== exp_a[got]) begin
                    fails++; $display("FAIL rnd_flit%0d got %h want %h", got, if_a.data, exp_a[got]);
                end
                got++;
            end
            prev_stall = (if_a.valid === 1'b1) && !rdy;
            prev_dat = if_a.data;
        end
        tests++; if (got != 8) begin fails++; $display("FAIL rnd_timeout got %0d flits want 8", got); end
        @(negedge clk);
        tests++; if (done_a !== 1'b1 || sent_a !== 16'd2) begin
            fails++; $display("FAIL rnd_done got done=%b sent=%0d want 1/2", done_a, sent_a);
        end
    endtask

    initial begin
        exp_a = '{32'h4000_002A, 32'h002A_0001, 32'h002A_0002, 32'h802A_0003,
                  32'h4000_042A, 32'h002A_0001, 32'h002A_0002, 32'h802A_0003};
        exp_b = '{32'h4000_0155, 32'h8155_0001, 32'h0, 32'h0, 32'h0,
                  32'h4000_0555, 32'h8155_0001, 32'h0, 32'h0, 32'h0,
                  32'h4000_0955, 32'h8155_0001};
        vld_b = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        test_reset();
        test_basic();
        test_gap();
        test_busy_ignore();
        test_done_restart();
        test_deadlock();
        test_reset_mid();
        test_random_ready();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/virtual_stream_source.md
Name: virtual_stream_source

Overview:
- Traffic generator that sits directly upstream of a virtual PE's cast input (valid_i_cast / data_i_cast / ready_o_cast) or of a cast-network injection port.
- Emits a fixed number of fixed-length packets tagged with its stream id, under valid/ready backpressure.
- Detects stalls: flags a deadlock when a held flit goes unaccepted for too long. Used only for deadlock verification of the whole network; it carries no computational data.

Parameters:
- stream_id, 10'd0, 10-bit stream id written into every flit.
- PKT_NUM, 16, packets per run; range 1..65535.
- PKT_LEN, 8, flits per packet including head and tail; range 2..65535.
- GAP, 0, idle cycles inserted between the tail of one packet and the next head; range 0..255.
- TIMEOUT, 1024, consecutive stalled cycles that set the deadlock flag; must be ≥1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- start_i  in  1  run request; sampled only in IDLE or DONE
- valid_o  out  1  flit valid
- data_o  out  `DW  flit
- ready_i  in  1  downstream ready
- busy_o  out  1  run in progress (HEAD, BODY, TAIL or GAP state)
- done_o  out  1  sticky; all PKT_NUM packets accepted
- deadlock_o  out  1  sticky stall-timeout flag
- sent_cnt_o  out  16  packets fully accepted in the current run

Behaviour:
- Reset: asynchronous, active-low (rstn), single clock clk. While rstn is low: state=IDLE; valid_o, busy_o, done_o and deadlock_o are 0; sent_cnt_o=0; data_o=0; all internal counters are 0.
- `DW ≥ 32 is required.
- Flit format:
  - data_o[`DW-1:`DW-2] is the type: 2'b01 head, 2'b00 body, 2'b10 tail.
  - Head: [9:0]=stream_id, [25:10]=packet index (0-based).
  - Body and tail: [15:0]=flit index within the packet (head=0, so the first body flit is 1), [25:16]=stream_id.
  - All unused bits are 0.
- Handshake: a transfer occurs on a cycle where valid_o & ready_i is high.
  - Once raised, valid_o and data_o stay stable until that transfer.
  - valid_o never depends combinationally on ready_i.
  - Throughput is 1 flit/cycle when ready_i is held high.
- FSM:
  - IDLE: start_i=1 → HEAD on the next cycle. Packet index and flit index are zeroed, sent_cnt_o is cleared, done_o is cleared.
  - HEAD: valid_o=1. On transfer → BODY if PKT_LEN>2, else TAIL.
  - BODY: valid_o=1. The flit index increments on each transfer. The transfer of flit PKT_LEN-2 → TAIL.
  - TAIL: valid_o=1 with flit index PKT_LEN-1. On transfer, sent_cnt_o is incremented and the packet index is incremented. Next state:
    - the last packet was just sent → DONE;
    - otherwise GAP>0 → GAP;
    - otherwise → HEAD.
  - GAP: valid_o=0 for exactly GAP cycles, then → HEAD.
  - DONE: done_o=1 and busy_o=0. start_i=1 behaves as it does in IDLE: done_o clears and a new run begins the next cycle.
- start_i is ignored while busy_o=1.
- Latency: the first valid_o is asserted 1 cycle after start_i is sampled. done_o rises 1 cycle after the final tail transfer.
- Watchdog:
  - A 32-bit stall counter increments on each cycle where valid_o & ~ready_i is high.
  - It clears on any transfer and whenever valid_o=0.
  - When the counter reaches TIMEOUT, deadlock_o is set and stays set until reset.
  - The counter saturates; it does not wrap.
  - Transmission continues normally after deadlock_o is set; the flag is diagnostic only.
- Reset asserted mid-packet: all outputs return to their reset values immediately; no partial-packet recovery.
- A stall on a head, body or tail flit affects nothing but the watchdog; packet framing is preserved.

Test Plan:
- PKT_NUM=2, PKT_LEN=4, GAP=0, stream_id=10'h2A, ready_i=1, start pulse → 8 consecutive valid cycles with types 01,00,00,10,01,00,00,10. Head data [25:10] is 0 then 1, [9:0]=0x2A. done_o=1 and sent_cnt_o=2 one cycle after the last tail.
- PKT_LEN=2, GAP=3, PKT_NUM=3 → head,tail,3 idle,head,tail,3 idle,head,tail. No body flits. Total 12 cycles from first valid to done_o.
- Random ready_i with 30% probability → data_o stable on every valid & ~ready cycle. Received flit sequence identical to the ready_i=1 case.
- TIMEOUT=16, ready_i held low during the first body flit → deadlock_o rises after exactly 16 stalled cycles. Releasing ready_i completes the run with deadlock_o still 1.
- rstn pulsed low mid-BODY (flit 2 of 8) → valid_o=0 and all outputs 0 asynchronously. A later start_i produces a fresh run starting at packet 0.
- start_i asserted while busy → ignored, no restart. start_i in DONE → done_o clears and sent_cnt_o=0 the next cycle, and a new head appears.
